// File: rtl/tetris_pkg.sv
// Shared playfield geometry, offset width and checker state encoding.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int OFF_W   = 5;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CHECK,
      DONE
   } state_t;

endpackage

// File: rtl/tetron_cell_addr.sv
// Absolute cell address of one piece block: anchor + offset, with playfield bounds test.
module tetron_cell_addr #(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H
) (
   input  logic [tetris_pkg::OFF_W-1:0] pos_row,
   input  logic [tetris_pkg::OFF_W-1:0] pos_col,
   input  logic [tetris_pkg::OFF_W-1:0] voff,
   input  logic [tetris_pkg::OFF_W-1:0] hoff,
   output logic [tetris_pkg::OFF_W-1:0] abs_row,
   output logic [tetris_pkg::OFF_W-1:0] abs_col,
   output logic                         oob
);

   import tetris_pkg::*;

   localparam logic [OFF_W:0] ROW_LIM = BOARD_H[OFF_W:0];
   localparam logic [OFF_W:0] COL_LIM = BOARD_W[OFF_W:0];

   logic [OFF_W:0] row_sum;
   logic [OFF_W:0] col_sum;

   // One extra bit so anchor+offset never wraps back into the board.
   always_comb begin
      row_sum = {1'b0, pos_row} + {1'b0, voff};
      col_sum = {1'b0, pos_col} + {1'b0, hoff};
      oob     = (row_sum >= ROW_LIM) || (col_sum >= COL_LIM);
      abs_row = row_sum[OFF_W-1:0];
      abs_col = col_sum[OFF_W-1:0];
   end

endmodule

// File: rtl/tetron_collision_checker.sv
// Walks the four blocks of a candidate placement and flags wall, floor or locked-cell overlap.
module tetron_collision_checker #(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [tetris_pkg::OFF_W-1:0] pos_row,
   input  logic [tetris_pkg::OFF_W-1:0] pos_col,
   input  logic [tetris_pkg::OFF_W-1:0] blk1_voffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk2_voffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk3_voffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk4_voffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk1_hoffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk2_hoffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk3_hoffset,
   input  logic [tetris_pkg::OFF_W-1:0] blk4_hoffset,
   output logic                         board_rd_en,
   output logic [tetris_pkg::OFF_W-1:0] board_rd_row,
   input  logic [BOARD_W-1:0]           board_rd_data,
   output logic                         busy,
   output logic                         done,
   output logic                         collision
);

   import tetris_pkg::*;

   state_t           state;
   logic [1:0]       idx;
   logic [OFF_W-1:0] row_q;
   logic [OFF_W-1:0] col_q;
   logic [OFF_W-1:0] voff_q [4];
   logic [OFF_W-1:0] hoff_q [4];
   logic [OFF_W-1:0] hit_col_q;

   logic [OFF_W-1:0] abs_row;
   logic [OFF_W-1:0] abs_col;
   logic             oob;
   logic [BOARD_W-1:0] row_shift;
   logic             cell_hit;

   tetron_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H)
   ) u_cell_addr (
      .pos_row (row_q),
      .pos_col (col_q),
      .voff    (voff_q[idx]),
      .hoff    (hoff_q[idx]),
      .abs_row (abs_row),
      .abs_col (abs_col),
      .oob     (oob)
   );

   always_comb begin
      row_shift    = board_rd_data >> hit_col_q;
      cell_hit     = row_shift[0];
      board_rd_en  = (state == READ) && !oob;
      board_rd_row = board_rd_en ? abs_row : '0;
   end

   // collision is written on the edge entering DONE so it is valid alongside done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         collision <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         hit_col_q <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            voff_q[i] <= '0;
            hoff_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  row_q     <= pos_row;
                  col_q     <= pos_col;
                  voff_q[0] <= blk1_voffset;
                  voff_q[1] <= blk2_voffset;
                  voff_q[2] <= blk3_voffset;
                  voff_q[3] <= blk4_voffset;
                  hoff_q[0] <= blk1_hoffset;
                  hoff_q[1] <= blk2_hoffset;
                  hoff_q[2] <= blk3_hoffset;
                  hoff_q[3] <= blk4_hoffset;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= READ;
               end
            end
            READ: begin
               if (oob) begin
                  collision <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  hit_col_q <= abs_col;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (cell_hit) begin
                  collision <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (idx == 2'd3) begin
                  collision <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= READ;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
